conv_engine: RTL and testbench

Sequential 3x3 convolution and 3x3 max-pool engine that sits directly downstream of the memory module. It consumes the packed 4x4 DATA matrix and the 3x3 FILTER matrix, and computes the four stride-1 windows one tap per cycle. It returns two packed 2x2 results: convolution (ret22) and window maximum (ret33). Completion is signalled on CS, which the memory module uses to latch both results.

---
 rtl/conv_engine_pkg.sv | 49 ++++
 rtl/conv_tap_sel.sv | 28 ++
 rtl/conv_engine.sv | 128 ++++++++++++
 tb/tb_conv_engine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/conv_engine_pkg.sv
// Shared codes, matrix sizes and FSM encoding for the 3x3 convolution / max-pool engine.
package conv_engine_pkg;

    localparam logic [1:0] S_INIT    = 2'b00;
    localparam logic [1:0] S_MEMINIT = 2'b01;
    localparam logic [1:0] S_CALC    = 2'b10;
    localparam logic [1:0] MS_READY  = 2'b10;
    localparam logic [1:0] CS_IDLE   = 2'b00;
    localparam logic [1:0] CS_DONE   = 2'b01;

    localparam int DATA_N = 4;
    localparam int FILT_N = 3;
    localparam int OUT_N  = 2;
    localparam int ACC_W  = 20;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = FILT_N * FILT_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } fsm_t;

    typedef struct packed {
        logic [1:0] u;
        logic [1:0] v;
    } tap_t;

    // Tap index t (0..8) split into filter row u = t/3 and column v = t%3.
    function automatic tap_t tap_split(input logic [3:0] t);
        tap_t r;
        case (t)
            4'd0:    r = '{u: 2'd0, v: 2'd0};
            4'd1:    r = '{u: 2'd0, v: 2'd1};
            4'd2:    r = '{u: 2'd0, v: 2'd2};
            4'd3:    r = '{u: 2'd1, v: 2'd0};
            4'd4:    r = '{u: 2'd1, v: 2'd1};
            4'd5:    r = '{u: 2'd1, v: 2'd2};
            4'd6:    r = '{u: 2'd2, v: 2'd0};
            4'd7:    r = '{u: 2'd2, v: 2'd1};
            4'd8:    r = '{u: 2'd2, v: 2'd2};
            default: r = '{u: 2'd0, v: 2'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/conv_tap_sel.sv
// Maps (window w, tap t) onto the captured DATA/FILTER registers and returns the two operand bytes.
module conv_tap_sel
    import conv_engine_pkg::*;
(
    input  logic [DATA_N*DATA_N*DATA_W-1:0] data_q,
    input  logic [FILT_N*FILT_N*COEF_W-1:0] filt_q,
    input  logic [1:0]                      w,
    input  logic [3:0]                      t,
    output logic [DATA_W-1:0]               d_sel,
    output logic [COEF_W-1:0]               f_sel
);

    tap_t       tap;
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] d_idx;

    always_comb begin
        tap   = tap_split(t);
        row   = {1'b0, w[1]} + tap.u;
        col   = {1'b0, w[0]} + tap.v;
        // 4x4 row-major index is simply {row, col}; the filter index equals t itself
        d_idx = {row, col};
        d_sel = data_q[{d_idx, 3'b000} +: DATA_W];
        f_sel = filt_q[{t, 3'b000} +: COEF_W];
    end

endmodule

// File: rtl/conv_engine.sv
// Sequential 3x3 convolution + 3x3 max-pool over the four stride-1 windows of a 4x4 matrix, one tap per cycle.
module conv_engine
    import conv_engine_pkg::*;
#(
    parameter int SHIFT = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   state,
    input  logic [1:0]   MS,
    input  logic [127:0] DATA,
    input  logic [71:0]  FILTER,
    output logic [1:0]   CS,
    output logic [31:0]  ret22,
    output logic [31:0]  ret33
);

    fsm_t cur_st;
    fsm_t nxt_st;

    logic [127:0]      data_q;
    logic [71:0]       filt_q;
    logic [1:0]        w;
    logic [3:0]        t;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] mx;

    logic [DATA_W-1:0] d_sel;
    logic [COEF_W-1:0] f_sel;
    logic [15:0]       prod;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] mx_nxt;
    logic              start;
    logic              last_tap;
    logic              last_win;

    function automatic logic [DATA_W-1:0] sat_shift(input logic [ACC_W-1:0] s);
        logic [ACC_W-1:0] sh;
        sh = s >> SHIFT;
        return (sh > ACC_W'(255)) ? 8'hFF : sh[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] max8(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    conv_tap_sel u_tap_sel (
        .data_q (data_q),
        .filt_q (filt_q),
        .w      (w),
        .t      (t),
        .d_sel  (d_sel),
        .f_sel  (f_sel)
    );

    assign start    = (state == S_CALC) && (MS == MS_READY);
    assign last_tap = (t == 4'd8);
    assign last_win = (w == 2'd3);
    assign prod     = 16'(d_sel) * 16'(f_sel);
    assign sum      = acc + ACC_W'(prod);
    assign mx_nxt   = max8(mx, d_sel);

    always_ff @(posedge clk) begin
        if (rst) cur_st <= IDLE;
        else     cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE: if (start) nxt_st = LOAD;
            LOAD: nxt_st = MAC;
            MAC:  if (last_tap && last_win) nxt_st = DONE;
            // state must leave CALC before another run can be armed
            DONE: if (state != S_CALC) nxt_st = IDLE;
            default: nxt_st = IDLE;
        endcase
    end

    always_comb begin
        CS = (cur_st == DONE) ? CS_DONE : CS_IDLE;
    end

    // Operand capture: data registers only, no reset needed
    always_ff @(posedge clk) begin
        if (cur_st == LOAD) begin
            data_q <= DATA;
            filt_q <= FILTER;
        end
    end

    // Accumulate / max-track stage; results written per completed window
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mx    <= '0;
            w     <= '0;
            t     <= '0;
            ret22 <= '0;
            ret33 <= '0;
        end else begin
            case (cur_st)
                LOAD: begin
                    acc <= '0;
                    mx  <= '0;
                    w   <= '0;
                    t   <= '0;
                end
                MAC: begin
                    if (last_tap) begin
                        ret22[{w, 3'b000} +: 8] <= sat_shift(sum);
                        ret33[{w, 3'b000} +: 8] <= mx_nxt;
                        acc <= '0;
                        mx  <= '0;
                        t   <= '0;
                        w   <= w + 2'd1;
                    end else begin
                        acc <= sum;
                        mx  <= mx_nxt;
                        t   <= t + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: directed scenarios plus random matrices against a window-level model.
module tb_conv_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   state;
    logic [1:0]   MS;
    logic [127:0] DATA;
    logic [71:0]  FILTER;
    logic [1:0]   CS;
    logic [31:0]  ret22;
    logic [31:0]  ret33;

    int vectors = 0;
    int miscompares = 0;

    int d [16];
    int f [9];
    logic [31:0] exp22;
    logic [31:0] exp33;

    always #5 clk = ~clk;

    conv_engine #(.SHIFT(10)) dut (
        .clk    (clk),
        .rst    (rst),
        .state  (state),
        .MS     (MS),
        .DATA   (DATA),
        .FILTER (FILTER),
        .CS     (CS),
        .ret22  (ret22),
        .ret33  (ret33)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_mats();
        for (int k = 0; k < 16; k++) DATA[k*8 +: 8] = 8'(d[k]);
        for (int k = 0; k < 9; k++) FILTER[k*8 +: 8] = 8'(f[k]);
    endtask

    // Window-level reference: full 3x3 dot product and max, then shift and clamp
    task automatic model();
        int s, m, b;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                m = 0;
                for (int u = 0; u < 3; u++) begin
                    for (int v = 0; v < 3; v++) begin
                        s += d[(i+u)*4 + j+v] * f[u*3+v];
                        if (d[(i+u)*4 + j+v] > m) m = d[(i+u)*4 + j+v];
                    end
                end
                b = s >> 10;
                if (b > 255) b = 255;
                exp22[(i*2+j)*8 +: 8] = 8'(b);
                exp33[(i*2+j)*8 +: 8] = 8'(m);
            end
        end
    endtask

    // Raise start, count edges after the start edge until CS=01; optionally zero DATA mid-run
    task automatic run(input string tag, input bit zero_mid);
        int c;
        drive_mats();
        state = 2'b10;
        MS    = 2'b10;
        @(negedge clk);
        c = 0;
        while (CS !== 2'b01 && c < 200) begin
            @(negedge clk);
            c++;
            if (zero_mid && c == 10) DATA = '0;
        end
        chk({tag, "_latency"}, 32'(c), 32'd37);
        model();
        chk({tag, "_ret22"}, ret22, exp22);
        chk({tag, "_ret33"}, ret33, exp33);
    endtask

    task automatic set_scn1();
        int dd [16] = '{41,35,190,132, 225,108,214,174, 82,144,73,241, 241,187,233,235};
        int ff [9]  = '{179,166,219, 60,135,12, 62,153,36};
        d = dd;
        f = ff;
    endtask

    task automatic leave_calc();
        state = 2'b01;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; state = 2'b00; MS = 2'b00; DATA = '0; FILTER = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cs", 32'(CS), 32'd0);
        chk("reset_ret22", ret22, 32'd0);
        chk("reset_ret33", ret33, 32'd0);

        set_scn1();
        run("scn1", 1'b0);
        chk("scn1_const22", ret22, 32'hA6B18170);
        chk("scn1_const33", ret33, 32'hF1F1F1E1);

        // Holding CALC after DONE must not restart
        repeat (10) @(negedge clk);
        chk("hold_done_cs", 32'(CS), 32'd1);
        state = 2'b01;
        @(negedge clk);
        chk("drop_state_cs", 32'(CS), 32'd0);
        chk("idle_keep22", ret22, 32'hA6B18170);
        run("rearm", 1'b0);
        leave_calc();

        for (int k = 0; k < 16; k++) d[k] = 255;
        for (int k = 0; k < 9; k++) f[k] = 255;
        run("sat", 1'b0);
        chk("sat_const22", ret22, 32'hFFFFFFFF);
        leave_calc();

        // Abort in the middle of MAC
        set_scn1();
        drive_mats();
        state = 2'b10; MS = 2'b10;
        repeat (22) @(negedge clk);
        chk("mid_cs_busy", 32'(CS), 32'd0);
        rst = 1'b1; state = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cs", 32'(CS), 32'd0);
        chk("abort_ret22", ret22, 32'd0);
        chk("abort_ret33", ret33, 32'd0);
        @(negedge clk);
        run("after_abort", 1'b0);
        leave_calc();

        run("zero_mid", 1'b1);
        chk("zero_mid_const22", ret22, 32'hA6B18170);
        leave_calc();

        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 16; k++) d[k] = int'($urandom_range(0, 255));
            for (int k = 0; k < 9; k++) f[k] = int'($urandom_range(0, 255));
            if (n < 3) for (int k = 0; k < 9; k++) f[k] = f[k] / 8;
            run("rand", 1'b0);
            leave_calc();
        end

        // Memory not ready: engine must stay idle
        state = 2'b10; MS = 2'b01;
        repeat (50) @(negedge clk);
        chk("ms_not_ready_cs", 32'(CS), 32'd0);
        state = 2'b00; MS = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
